// File: rtl/inst_rom_arbiter_pkg.sv
// Shared definitions for the instruction ROM read-port arbiter: bus widths,
// ROM control encodings and the arbitration FSM state type.
package inst_rom_arbiter_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int STARVE_W    = 4;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

  typedef enum logic {
    ST_FPRI   = 1'b0,
    ST_AFORCE = 1'b1
  } arb_state_e;

  // Word-aligned check on the two low byte-address bits.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_rom_starve_cnt.sv
// Tracks how long the auxiliary port has been denied and raises a one-cycle
// force flag that hands it priority over fetch.
module inst_rom_starve_cnt
  import inst_rom_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic a_gnt,
  output logic a_force
);

  localparam logic [STARVE_W-1:0] CntLast = STARVE_W'(STARVE_MAX - 1);

  arb_state_e          state, state_next;
  logic [STARVE_W-1:0] cnt;
  logic                a_denied;

  assign a_denied = a_req & ~a_gnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FPRI;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (a_denied) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // NOTE: the default assignment up front keeps this block free of latches
  // even if a case arm is later added without assigning state_next.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_FPRI:   if (a_denied && (cnt == CntLast)) state_next = ST_AFORCE;
      ST_AFORCE: state_next = ST_FPRI;
      default:   state_next = ST_FPRI;
    endcase
  end

  always_comb begin
    a_force = (state == ST_AFORCE);
  end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the instruction ROM read port between fetch (F) and an auxiliary
// reader (A), with a fixed one-cycle registered response per grant.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = InstAddrBus,
  parameter int DATA_W     = InstBus,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  output logic              stallreq_if,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  logic              a_force;
  logic              any_gnt;
  logic              sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] rd_word;

  inst_rom_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .a_req  (a_req),
    .a_gnt  (a_gnt),
    .a_force(a_force)
  );

  always_comb begin
    if (a_force) begin
      a_gnt = a_req;
      f_gnt = f_req & ~a_req;
    end else begin
      f_gnt = f_req;
      a_gnt = a_req & ~f_req;
    end
    stallreq_if = f_req & ~f_gnt;
  end

  always_comb begin
    any_gnt  = f_gnt | a_gnt;
    sel_addr = a_gnt ? a_addr : (f_gnt ? f_addr : ADDR_W'(ZeroWord));
    sel_mis  = any_gnt && is_misaligned(sel_addr[1:0]);
    // A misaligned grant keeps its slot but never touches the ROM.
    rom_ce   = (any_gnt && !sel_mis) ? ChipEnable : ChipDisable;
    rom_addr = sel_addr;
    rd_word  = sel_mis ? DATA_W'(ZeroWord) : rom_inst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_rvalid <= 1'b0;
      f_err    <= 1'b0;
      f_rdata  <= DATA_W'(ZeroWord);
    end else begin
      f_rvalid <= f_gnt & ~f_flush;
      f_err    <= f_gnt & ~f_flush & sel_mis;
      if (f_gnt && !f_flush) begin
        f_rdata <= rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
      a_rdata  <= DATA_W'(ZeroWord);
    end else begin
      a_rvalid <= a_gnt;
      a_err    <= a_gnt & sel_mis;
      if (a_gnt) begin
        a_rdata <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter: reset, idle, fetch streaming,
// starvation forcing, misaligned access, flush and mid-response reset.
module tb_inst_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_flush;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        stallreq_if;
  logic        a_req;
  logic [31:0] a_addr;
  logic        a_gnt;
  logic        a_rvalid;
  logic [31:0] a_rdata;
  logic        a_err;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  int n_assert = 0;
  int n_fail   = 0;

  inst_rom_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_flush    (f_flush),
    .f_gnt      (f_gnt),
    .f_rvalid   (f_rvalid),
    .f_rdata    (f_rdata),
    .f_err      (f_err),
    .stallreq_if(stallreq_if),
    .a_req      (a_req),
    .a_addr     (a_addr),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .a_err      (a_err),
    .rom_ce     (rom_ce),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst)
  );

  // ROM word n holds 0x1000_0000 + n; a disabled ROM returns a poison value.
  assign rom_inst = rom_ce ? (32'h1000_0000 | {2'b00, rom_addr[31:2]}) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 1ns later, mid-cycle.
  task automatic drive(input logic fr, input logic [31:0] fa, input logic ff,
                       input logic ar, input logic [31:0] aa);
    @(negedge clk);
    f_req   = fr;
    f_addr  = fa;
    f_flush = ff;
    a_req   = ar;
    a_addr  = aa;
    #1;
  endtask

  logic exp_a;

  initial begin
    rst = 1'b0; f_req = 1'b0; f_addr = '0; f_flush = 1'b0; a_req = 1'b0; a_addr = '0;
    #3;
    check("rst_f_rvalid", f_rvalid, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_f_err", f_err, 0);
    check("rst_a_err", a_err, 0);
    check("rst_f_rdata", f_rdata, 0);
    check("rst_a_rdata", a_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // Idle
    drive(0, 32'h0, 0, 0, 32'h0);
    check("idle_rom_ce", rom_ce, 0);
    check("idle_rom_addr", rom_addr, 0);
    check("idle_f_gnt", f_gnt, 0);
    check("idle_a_gnt", a_gnt, 0);
    check("idle_stall", stallreq_if, 0);
    drive(0, 32'h0, 0, 0, 32'h0);
    check("idle_f_rvalid", f_rvalid, 0);
    check("idle_a_rvalid", a_rvalid, 0);

    // Fetch only: 0x0, 0x4, 0x8
    drive(1, 32'h0, 0, 0, 32'h0);
    check("fo0_f_gnt", f_gnt, 1);
    check("fo0_rom_ce", rom_ce, 1);
    check("fo0_stall", stallreq_if, 0);
    drive(1, 32'h4, 0, 0, 32'h0);
    check("fo1_f_gnt", f_gnt, 1);
    check("fo1_rom_addr", rom_addr, 32'h4);
    check("fo1_f_rvalid", f_rvalid, 1);
    check("fo1_f_rdata", f_rdata, 32'h1000_0000);
    drive(1, 32'h8, 0, 0, 32'h0);
    check("fo2_f_gnt", f_gnt, 1);
    check("fo2_f_rvalid", f_rvalid, 1);
    check("fo2_f_rdata", f_rdata, 32'h1000_0001);
    check("fo2_stall", stallreq_if, 0);
    drive(0, 32'h0, 0, 0, 32'h0);
    check("fo3_f_rvalid", f_rvalid, 1);
    check("fo3_f_rdata", f_rdata, 32'h1000_0002);
    check("fo3_f_err", f_err, 0);
    check("fo3_a_rvalid", a_rvalid, 0);

    // Contention: A denied four cycles, forced on the fifth, period five
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h20, 0, 1, 32'h40);
      exp_a = (k == 4) || (k == 9);
      check($sformatf("cont%0d_a_gnt", k), a_gnt, exp_a);
      check($sformatf("cont%0d_f_gnt", k), f_gnt, !exp_a);
      check($sformatf("cont%0d_stall", k), stallreq_if, exp_a);
      check($sformatf("cont%0d_rom_addr", k), rom_addr, exp_a ? 32'h40 : 32'h20);
      if (k == 5) begin
        check("cont5_a_rvalid", a_rvalid, 1);
        check("cont5_a_rdata", a_rdata, 32'h1000_0010);
        check("cont5_f_rvalid", f_rvalid, 0);
      end else if (k > 0) begin
        check($sformatf("cont%0d_f_rvalid", k), f_rvalid, 1);
        check($sformatf("cont%0d_f_rdata", k), f_rdata, 32'h1000_0008);
      end
    end
    drive(0, 32'h0, 0, 0, 32'h0);
    check("cont_end_a_rvalid", a_rvalid, 1);
    check("cont_end_f_rvalid", f_rvalid, 0);

    // Misaligned auxiliary access
    drive(0, 32'h0, 0, 1, 32'h6);
    check("mis_a_gnt", a_gnt, 1);
    check("mis_rom_ce", rom_ce, 0);
    check("mis_f_gnt", f_gnt, 0);
    drive(0, 32'h0, 0, 0, 32'h0);
    check("mis_a_rvalid", a_rvalid, 1);
    check("mis_a_err", a_err, 1);
    check("mis_a_rdata", a_rdata, 32'h0);

    // Flush leaves port A alone
    drive(0, 32'h0, 1, 1, 32'h8);
    check("aflush_a_gnt", a_gnt, 1);
    drive(0, 32'h0, 0, 0, 32'h0);
    check("aflush_a_rvalid", a_rvalid, 1);
    check("aflush_a_rdata", a_rdata, 32'h1000_0002);
    check("aflush_a_err", a_err, 0);

    // Fetch flush at 0x10, then fetch at 0x14
    drive(1, 32'h10, 1, 0, 32'h0);
    check("fl_f_gnt", f_gnt, 1);
    drive(1, 32'h14, 0, 0, 32'h0);
    check("fl_f_rvalid", f_rvalid, 0);
    check("fl_f_rdata_hold", f_rdata, 32'h1000_0008);
    drive(0, 32'h0, 0, 0, 32'h0);
    check("fl_next_f_rvalid", f_rvalid, 1);
    check("fl_next_f_rdata", f_rdata, 32'h1000_0005);

    // Misaligned fetch
    drive(1, 32'h3, 0, 0, 32'h0);
    check("fmis_f_gnt", f_gnt, 1);
    check("fmis_rom_ce", rom_ce, 0);
    drive(0, 32'h0, 0, 0, 32'h0);
    check("fmis_f_rvalid", f_rvalid, 1);
    check("fmis_f_err", f_err, 1);
    check("fmis_f_rdata", f_rdata, 32'h0);

    // Reset mid-response with the starvation counter part-way up
    drive(1, 32'h0, 0, 1, 32'h40);
    drive(1, 32'h4, 0, 1, 32'h40);
    drive(1, 32'h8, 0, 1, 32'h40);
    @(negedge clk);
    #1;
    check("prerst_f_rvalid", f_rvalid, 1);
    check("prerst_f_rdata", f_rdata, 32'h1000_0002);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_f_rvalid", f_rvalid, 0);
    check("midrst_f_rdata", f_rdata, 0);
    check("midrst_a_rvalid", a_rvalid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    // The release-cycle edge counts one denial, so the force lands at k=3.
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h0, 0, 1, 32'h40);
      check($sformatf("postrst%0d_a_gnt", k), a_gnt, k == 3);
      check($sformatf("postrst%0d_f_gnt", k), f_gnt, k != 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
